// File: rtl/uart_msg_scheduler.sv
// Serialises move/event reports into short ASCII messages for a byte-wide UART transmitter.
// One request slot per source; round-robin on ties; dropped requests are counted.
module uart_msg_scheduler #(
   parameter bit CRLF = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mv_valid,
   input  logic       mv_player,
   input  logic [3:0] mv_square,
   input  logic       mv_hit,
   input  logic       ev_valid,
   input  logic       ev_code,
   input  logic       ev_player,
   output logic       mv_ready,
   output logic       ev_ready,
   output logic [7:0] tx_byte,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic       busy,
   output logic       msg_done,
   output logic [7:0] drop_cnt
);
   typedef enum logic [1:0] {IDLE, SEND, WAIT, NEXT} state_t;
   typedef enum logic {GR_MV, GR_EV} grant_t;

   state_t          state_q, state_d;
   grant_t          last_q, last_d;
   logic            mv_pend_q, mv_pend_d, ev_pend_q, ev_pend_d;
   logic            mv_player_q, mv_player_d, mv_hit_q, mv_hit_d;
   logic [3:0]      mv_square_q, mv_square_d;
   logic            ev_code_q, ev_code_d, ev_player_q, ev_player_d;
   logic [7:0][7:0] msg_q, msg_d;
   logic [2:0]      idx_q, idx_d, last_idx_q, last_idx_d;
   logic [7:0]      tx_byte_q, drop_q, drop_d, hex;
   logic [8:0]      drop_sum;
   logic            gnt_mv, gnt_ev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= GR_EV;
         mv_pend_q   <= 1'b0;
         ev_pend_q   <= 1'b0;
         mv_player_q <= 1'b0;
         mv_hit_q    <= 1'b0;
         mv_square_q <= '0;
         ev_code_q   <= 1'b0;
         ev_player_q <= 1'b0;
         msg_q       <= '0;
         idx_q       <= '0;
         last_idx_q  <= '0;
         tx_byte_q   <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mv_pend_q   <= mv_pend_d;
         ev_pend_q   <= ev_pend_d;
         mv_player_q <= mv_player_d;
         mv_hit_q    <= mv_hit_d;
         mv_square_q <= mv_square_d;
         ev_code_q   <= ev_code_d;
         ev_player_q <= ev_player_d;
         msg_q       <= msg_d;
         idx_q       <= idx_d;
         last_idx_q  <= last_idx_d;
         tx_byte_q   <= tx_byte;
         drop_q      <= drop_d;
      end
   end

   // Tie goes to whichever source was not granted last.
   always_comb begin
      gnt_mv = (state_q == IDLE) && mv_pend_q && (!ev_pend_q || (last_q == GR_EV));
      gnt_ev = (state_q == IDLE) && ev_pend_q && !gnt_mv;
   end

   // Slots are tested against the pre-grant pend flag, so a slot freed this cycle refuses a request in the same cycle.
   always_comb begin
      mv_pend_d   = mv_pend_q && !gnt_mv;
      ev_pend_d   = ev_pend_q && !gnt_ev;
      mv_player_d = mv_player_q;
      mv_hit_d    = mv_hit_q;
      mv_square_d = mv_square_q;
      ev_code_d   = ev_code_q;
      ev_player_d = ev_player_q;
      if (mv_valid && !mv_pend_q) begin
         mv_pend_d   = 1'b1;
         mv_player_d = mv_player;
         mv_hit_d    = mv_hit;
         mv_square_d = mv_square;
      end
      if (ev_valid && !ev_pend_q) begin
         ev_pend_d   = 1'b1;
         ev_code_d   = ev_code;
         ev_player_d = ev_player;
      end
      drop_sum = {1'b0, drop_q} + {8'b0, mv_valid && mv_pend_q} + {8'b0, ev_valid && ev_pend_q};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_comb begin
      hex        = (mv_square_q < 4'd10) ? (8'h30 + {4'b0, mv_square_q}) : (8'h37 + {4'b0, mv_square_q});
      msg_d      = msg_q;
      last_idx_d = last_idx_q;
      last_d     = last_q;
      if (gnt_mv) begin
         msg_d      = '0;
         msg_d[0]   = 8'h50;
         msg_d[1]   = mv_player_q ? 8'h32 : 8'h31;
         msg_d[2]   = 8'h3A;
         msg_d[3]   = hex;
         msg_d[4]   = mv_hit_q ? 8'h48 : 8'h4D;
         msg_d[5]   = 8'h0D;
         msg_d[6]   = 8'h0A;
         last_idx_d = CRLF ? 3'd6 : 3'd4;
         last_d     = GR_MV;
      end else if (gnt_ev) begin
         msg_d      = '0;
         msg_d[0]   = ev_code_q ? 8'h52 : 8'h57;
         msg_d[1]   = ev_code_q ? 8'h53 : (ev_player_q ? 8'h32 : 8'h31);
         msg_d[2]   = 8'h0D;
         msg_d[3]   = 8'h0A;
         last_idx_d = CRLF ? 3'd3 : 3'd1;
         last_d     = GR_EV;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: if (gnt_mv || gnt_ev) begin
            state_d = SEND;
            idx_d   = '0;
         end
         SEND: if (!tx_busy) state_d = WAIT;
         WAIT: state_d = NEXT;
         NEXT: if (!tx_busy) begin
            if (idx_q == last_idx_q) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = SEND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // tx_byte shows the new byte in its start cycle and then holds it until the next start.
   always_comb begin
      tx_start = (state_q == SEND) && !tx_busy;
      msg_done = (state_q == NEXT) && !tx_busy && (idx_q == last_idx_q);
      busy     = (state_q != IDLE) || gnt_mv || gnt_ev;
      tx_byte  = tx_start ? msg_q[idx_q] : tx_byte_q;
      mv_ready = !mv_pend_q;
      ev_ready = !ev_pend_q;
      drop_cnt = drop_q;
   end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Randomised and directed bench for uart_msg_scheduler against a transaction-level reference model.
`timescale 1ns/1ps
module tb_uart_msg_scheduler;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       mv_valid, mv_player, mv_hit, ev_valid, ev_code, ev_player, tx_busy;
   logic [3:0] mv_square;
   logic       mv_ready, ev_ready, tx_start, busy, msg_done;
   logic [7:0] tx_byte, drop_cnt;
   logic       c0_mv_valid, c0_mv_player, c0_mv_hit, c0_ev_valid, c0_ev_code, c0_ev_player, c0_tx_busy;
   logic [3:0] c0_mv_square;
   logic       c0_mv_ready, c0_ev_ready, c0_tx_start, c0_busy, c0_msg_done;
   logic [7:0] c0_tx_byte, c0_drop_cnt;

   always #5 clk = ~clk;

   uart_msg_scheduler #(.CRLF(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .mv_valid(mv_valid), .mv_player(mv_player), .mv_square(mv_square),
      .mv_hit(mv_hit), .ev_valid(ev_valid), .ev_code(ev_code), .ev_player(ev_player),
      .mv_ready(mv_ready), .ev_ready(ev_ready), .tx_byte(tx_byte), .tx_start(tx_start),
      .tx_busy(tx_busy), .busy(busy), .msg_done(msg_done), .drop_cnt(drop_cnt));

   uart_msg_scheduler #(.CRLF(1'b0)) dut_nocrlf (
      .clk(clk), .rst_n(rst_n), .mv_valid(c0_mv_valid), .mv_player(c0_mv_player), .mv_square(c0_mv_square),
      .mv_hit(c0_mv_hit), .ev_valid(c0_ev_valid), .ev_code(c0_ev_code), .ev_player(c0_ev_player),
      .mv_ready(c0_mv_ready), .ev_ready(c0_ev_ready), .tx_byte(c0_tx_byte), .tx_start(c0_tx_start),
      .tx_busy(c0_tx_busy), .busy(c0_busy), .msg_done(c0_msg_done), .drop_cnt(c0_drop_cnt));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: two request slots, a queue of bytes still owed, and counters.
   bit         m_act, m_mvp, m_evp, m_last_ev, m_mv_pl, m_mv_hit, m_ev_code, m_ev_pl;
   int         m_mv_sq, m_left, m_drops, n_done, n_done_exp, n_starts, bcnt;
   logic [7:0] expq[$];
   logic [7:0] last_byte;
   bit         prev_start, force_busy;
   logic [7:0] c0q[$];
   int         c0_done;

   function automatic logic [7:0] hexd(input int s);
      return (s < 10) ? 8'(8'h30 + s) : 8'(8'h41 + (s - 10));
   endfunction

   task automatic push_move(input bit p, input int s, input bit h);
      expq.push_back(8'h50);
      expq.push_back(p ? 8'h32 : 8'h31);
      expq.push_back(8'h3A);
      expq.push_back(hexd(s));
      expq.push_back(h ? 8'h48 : 8'h4D);
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
      m_left = 7;
   endtask

   task automatic push_event(input bit code, input bit p);
      expq.push_back(code ? 8'h52 : 8'h57);
      expq.push_back(code ? 8'h53 : (p ? 8'h32 : 8'h31));
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
      m_left = 4;
   endtask

   task automatic model_eval();
      bit mvp0, evp0, act0, gm, ge;
      logic [7:0] eb;
      mvp0 = m_mvp; evp0 = m_evp; act0 = m_act; gm = 1'b0; ge = 1'b0;
      check_eq("mv_ready", mv_ready, !mvp0);
      check_eq("ev_ready", ev_ready, !evp0);
      check_eq("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
      if (!act0 && (mvp0 || evp0)) begin
         if (mvp0 && evp0) begin
            gm = m_last_ev; ge = !m_last_ev;
         end else begin
            gm = mvp0; ge = evp0;
         end
      end
      check_eq("busy", busy, act0 || gm || ge);
      if (tx_start) begin
         n_starts++;
         check_eq("start_gap", prev_start, 0);
         if (expq.size() == 0) check_eq("tx_unexpected", tx_start, 0);
         else begin
            eb = expq.pop_front();
            check_eq("tx_byte", tx_byte, eb);
            last_byte = eb;
            m_left--;
         end
         bcnt = $urandom_range(1, 6);
      end else begin
         check_eq("tx_hold", tx_byte, last_byte);
      end
      prev_start = tx_start;
      if (msg_done) begin
         check_eq("done_early", m_left, 0);
         check_eq("done_idle", act0, 1);
         m_act = 1'b0;
         n_done++;
      end
      if (gm) begin
         push_move(m_mv_pl, m_mv_sq, m_mv_hit);
         m_mvp = 1'b0; m_last_ev = 1'b0; m_act = 1'b1; n_done_exp++;
      end else if (ge) begin
         push_event(m_ev_code, m_ev_pl);
         m_evp = 1'b0; m_last_ev = 1'b1; m_act = 1'b1; n_done_exp++;
      end
      if (mv_valid) begin
         if (!mvp0) begin
            m_mvp = 1'b1; m_mv_pl = mv_player; m_mv_sq = int'(mv_square); m_mv_hit = mv_hit;
         end else m_drops++;
      end
      if (ev_valid) begin
         if (!evp0) begin
            m_evp = 1'b1; m_ev_code = ev_code; m_ev_pl = ev_player;
         end else m_drops++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_eval();
      if (c0_tx_start) c0q.push_back(c0_tx_byte);
      if (c0_msg_done) c0_done++;
      @(posedge clk);
      #1;
      if (force_busy) tx_busy = 1'b1;
      else begin
         if (bcnt == 0 && $urandom_range(0, 7) == 0) bcnt = $urandom_range(1, 3);
         tx_busy = (bcnt > 0);
         if (bcnt > 0) bcnt--;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; tx_busy = 1'b0; mv_valid = 1'b0; ev_valid = 1'b0;
      #1;
      check_eq("rst_tx_start", tx_start, 0);
      check_eq("rst_tx_byte", tx_byte, 0);
      check_eq("rst_msg_done", msg_done, 0);
      check_eq("rst_drop_cnt", drop_cnt, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_mv_ready", mv_ready, 1);
      check_eq("rst_ev_ready", ev_ready, 1);
      m_act = 1'b0; m_mvp = 1'b0; m_evp = 1'b0; m_last_ev = 1'b1; m_drops = 0; m_left = 0;
      expq.delete(); prev_start = 1'b0; last_byte = 8'h00; bcnt = 0; force_busy = 1'b0;
      n_done = 0; n_done_exp = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int k = 0;
      while ((m_act || m_mvp || m_evp) && k < 5000) begin
         step();
         k++;
      end
      check_eq("drain_timeout", (k < 5000), 1);
      check_eq("done_count", n_done, n_done_exp);
      check_eq("queue_empty", expq.size(), 0);
   endtask

   task automatic pulse_mv(input bit p, input int s, input bit h);
      mv_valid = 1'b1; mv_player = p; mv_square = s[3:0]; mv_hit = h;
      step();
      mv_valid = 1'b0;
   endtask

   task automatic pulse_ev(input bit code, input bit p);
      ev_valid = 1'b1; ev_code = code; ev_player = p;
      step();
      ev_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string hexs;
      int k, s0;
      bit p, h;
      hexs = "0123456789ABCDEF";
      mv_valid = 0; mv_player = 0; mv_square = 0; mv_hit = 0;
      ev_valid = 0; ev_code = 0; ev_player = 0; tx_busy = 0;
      c0_mv_valid = 0; c0_mv_player = 0; c0_mv_square = 0; c0_mv_hit = 0;
      c0_ev_valid = 0; c0_ev_code = 0; c0_ev_player = 0; c0_tx_busy = 0;
      n_starts = 0; c0_done = 0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single move: P2 square 11 hit.
      pulse_mv(1'b1, 11, 1'b1);
      drain();

      // Tie after reset goes to move; a second tie later goes to event.
      do_reset();
      mv_valid = 1; mv_player = 0; mv_square = 4'd3; mv_hit = 0;
      ev_valid = 1; ev_code = 0; ev_player = 0;
      step();
      mv_valid = 0; ev_valid = 0;
      repeat (12) step();
      pulse_mv(1'b1, 5, 1'b0);
      drain();

      // Overflow while a move sits in its slot behind an event.
      do_reset();
      pulse_ev(1'b1, 1'b0);
      repeat (3) pulse_mv(1'b0, 9, 1'b1);
      drain();
      check_eq("ovf_drops", drop_cnt, 2);

      // Long transmitter stall before the first byte.
      do_reset();
      force_busy = 1'b1; tx_busy = 1'b1;
      pulse_mv(1'b0, 7, 1'b0);
      s0 = n_starts;
      repeat (500) step();
      check_eq("stall_no_start", n_starts, s0);
      force_busy = 1'b0;
      k = 0;
      while (n_starts == s0 && k < 50) begin step(); k++; end
      check_eq("stall_release", n_starts, s0 + 1);
      drain();

      // Drop counter saturation.
      do_reset();
      force_busy = 1'b1; tx_busy = 1'b1;
      repeat (300) pulse_mv(1'($urandom), int'($urandom_range(0, 15)), 1'($urandom));
      check_eq("drop_sat", drop_cnt, 255);
      force_busy = 1'b0;
      drain();

      // Reset after three bytes of a move, then a restart event.
      do_reset();
      pulse_mv(1'b0, 2, 1'b1);
      k = 0;
      while (!(m_act && m_left == 4) && k < 200) begin step(); k++; end
      check_eq("mid_reach", m_left, 4);
      do_reset();
      repeat (20) step();
      pulse_ev(1'b1, 1'b0);
      drain();

      // CRLF=0 instance: square sweep, 5-byte messages.
      for (int s = 0; s < 16; s++) begin
         c0q.delete(); c0_done = 0;
         p = 1'($urandom); h = 1'($urandom);
         c0_mv_valid = 1; c0_mv_player = p; c0_mv_square = 4'(s); c0_mv_hit = h;
         step();
         c0_mv_valid = 0;
         k = 0;
         while (c0_done == 0 && k < 100) begin step(); k++; end
         repeat (4) step();
         check_eq("c0_len", c0q.size(), 5);
         check_eq("c0_done", c0_done, 1);
         if (c0q.size() == 5) begin
            check_eq("c0_p", c0q[0], 8'h50);
            check_eq("c0_player", c0q[1], p ? 8'h32 : 8'h31);
            check_eq("c0_colon", c0q[2], 8'h3A);
            check_eq("c0_hex", c0q[3], hexs[s]);
            check_eq("c0_hm", c0q[4], h ? 8'h48 : 8'h4D);
         end
      end

      // Random traffic with a randomly busy transmitter.
      do_reset();
      repeat (3000) begin
         mv_valid = ($urandom_range(0, 9) == 0); mv_player = 1'($urandom);
         mv_square = 4'($urandom); mv_hit = 1'($urandom);
         ev_valid = ($urandom_range(0, 11) == 0); ev_code = 1'($urandom); ev_player = 1'($urandom);
         step();
      end
      mv_valid = 0; ev_valid = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_msg_scheduler.md
UART_MSG_SCHEDULER -- requirements
Module: uart_msg_scheduler

Interface
REQ-001 Parameter: CRLF, default 1, when 1 every message ends with CR (0x0D) then LF (0x0A); when 0 both are omitted.
REQ-002 clk  in  1  system clock (100 MHz); all state changes on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 mv_valid  in  1  move-report request, one-cycle pulse.
REQ-005 mv_player  in  1  0 = P1, 1 = P2.
REQ-006 mv_square  in  4  target square, 0-15.
REQ-007 mv_hit  in  1  1 = hit, 0 = miss.
REQ-008 ev_valid  in  1  event-report request, one-cycle pulse.
REQ-009 ev_code  in  1  0 = win, 1 = restart.
REQ-010 ev_player  in  1  winning player for a win event (0 = P1, 1 = P2).
REQ-011 mv_ready, ev_ready  out  1 each  slot empty; each is combinationally the inverse of its pending flag.
REQ-012 tx_byte  out  8  byte to the UART transmitter.
REQ-013 tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-014 tx_busy  in  1  UART transmitter busy.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 msg_done  out  1  one-cycle pulse after the last byte's start is issued and the transmitter is free again.
REQ-017 drop_cnt  out  8  number of dropped requests, saturating at 255.

Function
REQ-018 Request capture:
- mv_valid while mv_ready=1 latches {player, square, hit} and sets mv_pend.
- mv_valid while mv_ready=0 is dropped and increments drop_cnt.
- ev_valid behaves the same way with ev_pend.
REQ-019 A slot freed by a grant in cycle N accepts a new request no earlier than cycle N+1. A request arriving in cycle N sees mv_ready as it was in cycle N.
REQ-020 FSM states are IDLE, SEND, WAIT and NEXT.
REQ-021 IDLE grant:
- If any pend flag is set, grant one requester.
- Copy the granted payload into the message register, clear its pend flag, set idx=0 and go to SEND.
- All of this happens in one cycle.
REQ-022 Arbitration:
- If only one flag is set, that requester is granted.
- If both are set, the requester opposite to last_grant is granted. last_grant resets to "event", so the first tie goes to move.
- last_grant updates on every grant.
REQ-023 SEND: when tx_busy=0, drive tx_byte=msg[idx], pulse tx_start for exactly one cycle, then go to WAIT. While tx_busy=1, stay in SEND with tx_start=0.
REQ-024 WAIT lasts exactly one cycle and absorbs the transmitter's busy-assert latency, then goes to NEXT.
REQ-025 NEXT:
- Wait for tx_busy=0.
- If idx is the last byte: pulse msg_done and go to IDLE.
- Otherwise: increment idx and go to SEND.
REQ-026 Move message bytes: "P", "1"/"2", ":", hex digit, "H"/"M", then CR, LF if CRLF=1. Length is 7, or 5 when CRLF=0.
REQ-027 Hex digit: square 0-9 maps to 0x30+square; square 10-15 maps to 0x41+(square-10). The result is computed in 8 bits.
REQ-028 Event message bytes: win is "W", "1"/"2"; restart is "R", "S"; then CR, LF if CRLF=1. Length is 4, or 2 when CRLF=0.
REQ-029 Each message is sent atomically; a pending request never interrupts a message already in progress.
REQ-030 tx_start is never high on two consecutive cycles.
REQ-031 tx_byte is stable from the tx_start cycle until the next tx_start.
REQ-032 drop_cnt saturates at 255 and never wraps.
REQ-033 busy=1 from the grant cycle through the msg_done cycle.

Reset
REQ-034 While rst_n=0, regardless of clk:
- outputs: tx_start=0, tx_byte=0x00, msg_done=0, drop_cnt=0, busy=0, mv_ready=1, ev_ready=1;
- internal: FSM=IDLE, both pend flags cleared, last_grant=event.
REQ-035 Reset asserted mid-message aborts the transfer immediately. No tx_start follows until a new request is accepted after rst_n rises.

Verification
REQ-036 Single move: mv_valid, player=1, square=11, hit=1, CRLF=1 -> bytes 0x50 0x32 0x3A 0x42 0x48 0x0D 0x0A, then one msg_done.
REQ-037 Tie: mv_valid and ev_valid (win, player=0) in the same cycle after reset -> move message first, then 0x57 0x31 0x0D 0x0A. A repeat tie grants event first.
REQ-038 Overflow: three mv_valid pulses while the first move is still pending -> two drops, drop_cnt=2, and only one move message is sent.
REQ-039 Busy stall: hold tx_busy=1 for 500 cycles before a byte -> tx_start stays low, then pulses once after tx_busy falls. No tx_start pulses occur on back-to-back cycles.
REQ-040 Reset mid-message: pull rst_n low after byte 3 -> tx_start=0, ready=1, drop_cnt=0. A fresh restart event then sends 0x52 0x53 0x0D 0x0A.
REQ-041 Square sweep 0-15 with CRLF=0 -> hex digits '0'-'9' then 'A'-'F', each in a 5-byte message.
